// File: rtl/dma_buffer_drain.sv
// Bus-side DMA drain engine: reads a block of words from the DMA buffer and
// writes it to system memory as a series of arbitrated write bursts.
module dma_buffer_drain #(
    parameter int BUFFER_ENTRIES = 512,
    parameter int ADDR_W         = $clog2(BUFFER_ENTRIES),
    parameter int MAX_BURST      = 256
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [31:0]       busStartAddress,
    input  logic [ADDR_W-1:0] bufferStartAddress,
    input  logic [ADDR_W:0]   blockSize,
    input  logic [7:0]        burstSize,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] bufAddress,
    input  logic [31:0]       bufReadData,
    output logic              requestBus,
    input  logic              busGrant,
    output logic              beginTransaction,
    output logic              endTransaction,
    output logic              readNotWrite,
    output logic [31:0]       addressData,
    output logic [7:0]        burstLength,
    output logic              dataValid,
    input  logic              busyIn,
    input  logic              errorIn
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int LEN_W   = (ADDR_W + 1 > BURST_W) ? ADDR_W + 1 : BURST_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_BEGIN,
        ST_DATA,
        ST_END,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [31:0]          busAddr;
    logic [ADDR_W-1:0]    bufIdx;
    logic [ADDR_W-1:0]    bufIdxNext;
    logic [ADDR_W:0]      remaining;
    logic [7:0]           burstSizeReg;
    logic [BURST_W-1:0]   burstCount;
    logic [LEN_W-1:0]     wantLen;
    logic [LEN_W-1:0]     grantLen;
    logic                 accept;
    logic                 lastWord;

    // Burst length granted on arbitration: smallest of the programmed burst,
    // the words still owed and the bus limit.
    always_comb begin
        wantLen  = LEN_W'(burstSizeReg) + LEN_W'(1);
        grantLen = wantLen;
        if (LEN_W'(remaining) < grantLen) begin
            grantLen = LEN_W'(remaining);
        end
        if (LEN_W'(MAX_BURST) < grantLen) begin
            grantLen = LEN_W'(MAX_BURST);
        end
    end

    assign accept     = (state == ST_DATA) && !busyIn;
    assign lastWord   = (burstCount == BURST_W'(1));
    assign bufIdxNext = (bufIdx == ADDR_W'(BUFFER_ENTRIES - 1)) ? '0 : bufIdx + ADDR_W'(1);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext        = state;
        busy             = (state != ST_IDLE);
        done             = 1'b0;
        requestBus       = 1'b0;
        beginTransaction = 1'b0;
        endTransaction   = 1'b0;
        readNotWrite     = 1'b0;
        addressData      = '0;
        burstLength      = '0;
        dataValid        = 1'b0;
        bufAddress       = bufIdx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stateNext = (blockSize == '0) ? ST_DONE : ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                requestBus = 1'b1;
                if (busGrant) begin
                    stateNext = ST_BEGIN;
                end
            end
            ST_BEGIN: begin
                requestBus       = 1'b1;
                beginTransaction = 1'b1;
                addressData      = busAddr;
                burstLength      = 8'(burstCount - BURST_W'(1));
                stateNext        = errorIn ? ST_DONE : ST_DATA;
            end
            // Prefetch the next word on an accept so the stream has no bubbles.
            ST_DATA: begin
                requestBus  = 1'b1;
                dataValid   = 1'b1;
                addressData = bufReadData;
                if (accept) begin
                    bufAddress = bufIdxNext;
                end
                if (errorIn) begin
                    stateNext = ST_DONE;
                end else if (accept && lastWord) begin
                    stateNext = ST_END;
                end
            end
            ST_END: begin
                endTransaction = 1'b1;
                stateNext      = (remaining != '0) ? ST_REQUEST : ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            busAddr      <= '0;
            bufIdx       <= '0;
            remaining    <= '0;
            burstSizeReg <= '0;
            burstCount   <= '0;
            error        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busAddr      <= busStartAddress & 32'hFFFF_FFFC;
                        bufIdx       <= bufferStartAddress;
                        remaining    <= blockSize;
                        burstSizeReg <= burstSize;
                        error        <= 1'b0;
                    end
                end
                ST_REQUEST: begin
                    if (busGrant) begin
                        burstCount <= BURST_W'(grantLen);
                    end
                end
                ST_BEGIN: begin
                    if (errorIn) begin
                        error <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        bufIdx     <= bufIdxNext;
                        busAddr    <= busAddr + 32'd4;
                        remaining  <= remaining - (ADDR_W + 1)'(1);
                        burstCount <= burstCount - BURST_W'(1);
                    end
                    if (errorIn) begin
                        error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_buffer_drain.sv
// Self-checking bench for dma_buffer_drain: table-driven transfers, corner
// sequences and randomized transfers against a burst/word reference model.
module tb_dma_buffer_drain;

    localparam int ENTRIES = 512;
    localparam int AW      = 9;
    localparam int MAXB    = 256;
    localparam int BUDGET  = 4000;

    logic          clock = 1'b0;
    logic          nReset;
    logic          start;
    logic [31:0]   busStartAddress;
    logic [AW-1:0] bufferStartAddress;
    logic [AW:0]   blockSize;
    logic [7:0]    burstSize;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] bufAddress;
    logic [31:0]   bufReadData;
    logic          requestBus;
    logic          busGrant;
    logic          beginTransaction;
    logic          endTransaction;
    logic          readNotWrite;
    logic [31:0]   addressData;
    logic [7:0]    burstLength;
    logic          dataValid;
    logic          busyIn;
    logic          errorIn;

    logic [31:0]   mem [ENTRIES];
    int            checks = 0;
    int            errors = 0;

    dma_buffer_drain #(
        .BUFFER_ENTRIES(ENTRIES),
        .ADDR_W(AW),
        .MAX_BURST(MAXB)
    ) dut (
        .clock(clock),
        .nReset(nReset),
        .start(start),
        .busStartAddress(busStartAddress),
        .bufferStartAddress(bufferStartAddress),
        .blockSize(blockSize),
        .burstSize(burstSize),
        .busy(busy),
        .done(done),
        .error(error),
        .bufAddress(bufAddress),
        .bufReadData(bufReadData),
        .requestBus(requestBus),
        .busGrant(busGrant),
        .beginTransaction(beginTransaction),
        .endTransaction(endTransaction),
        .readNotWrite(readNotWrite),
        .addressData(addressData),
        .burstLength(burstLength),
        .dataValid(dataValid),
        .busyIn(busyIn),
        .errorIn(errorIn)
    );

    always #5 clock = ~clock;

    // Buffer memory with a registered one-cycle read port
    always @(posedge clock) begin
        bufReadData <= mem[bufAddress];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transfer and checks bus traffic against the reference model
    task automatic applyStimulus(input logic [31:0] busStart, input int bufStart, input int blockSz,
                                 input int burstSz, input int grantPct, input int stallPct,
                                 input logic [31:0] stallMask, input int errorAt, input int midStartCyc,
                                 output int nBursts, output int doneCycOut);
        int          expLen[$];
        logic [31:0] expAddr[$];
        logic [31:0] expWords[$];
        logic [31:0] gotAddr[$];
        int          gotLen[$];
        int          gotAcc[$];
        int          gotDataCyc[$];
        int          gotStall[$];
        logic [31:0] gotWords[$];
        int          rem, len, cyc, doneCyc, dataCyc, errCyc, viol, endCnt, doneCnt;
        int          acc, dcyc, stl, mism;
        logic [31:0] a, prevWord;
        logic        prevHeld, reqSeen, errAtDone;

        rem = blockSz;
        a   = busStart & 32'hFFFF_FFFC;
        while (rem > 0) begin
            len = burstSz + 1;
            if (rem < len) len = rem;
            if (MAXB < len) len = MAXB;
            expAddr.push_back(a);
            expLen.push_back(len);
            a   = a + 32'(4 * len);
            rem = rem - len;
        end
        for (int i = 0; i < blockSz; i++) begin
            expWords.push_back(mem[(bufStart + i) % ENTRIES]);
        end

        @(posedge clock);
        #1;
        start              = 1'b1;
        busStartAddress    = busStart;
        bufferStartAddress = AW'(bufStart);
        blockSize          = (AW + 1)'(blockSz);
        burstSize          = 8'(burstSz);
        busGrant           = (int'($urandom_range(99)) < grantPct);
        busyIn             = 1'b0;
        errorIn            = 1'b0;
        cyc = 0; doneCyc = -1; dataCyc = 0; errCyc = -1; viol = 0; endCnt = 0; doneCnt = 0;
        acc = 0; dcyc = 0; stl = 0; prevHeld = 1'b0; prevWord = '0; reqSeen = 1'b0; errAtDone = 1'b0;

        forever begin
            @(negedge clock);
            cyc++;
            if (cyc == 1 && busy) viol++;
            if (cyc >= 2 && doneCyc < 0 && !busy) viol++;
            if (doneCyc >= 0 && busy) viol++;
            if (requestBus) reqSeen = 1'b1;
            if (readNotWrite) viol++;
            if (!beginTransaction && !dataValid && !endTransaction && (addressData != 0 || burstLength != 0)) viol++;
            if (int'(beginTransaction) + int'(dataValid) + int'(endTransaction) > 1) viol++;
            if (endTransaction && requestBus) viol++;
            if (beginTransaction) begin
                gotAddr.push_back(addressData);
                gotLen.push_back(int'(burstLength) + 1);
                acc = 0; dcyc = 0; stl = 0;
            end
            if (dataValid) begin
                dcyc++;
                if (busyIn) stl++;
                if (prevHeld && addressData !== prevWord) viol++;
                if (!busyIn && !errorIn) begin
                    gotWords.push_back(addressData);
                    acc++;
                end
                prevHeld = busyIn;
                prevWord = addressData;
            end else begin
                prevHeld = 1'b0;
            end
            if (endTransaction) begin
                endCnt++;
                gotAcc.push_back(acc);
                gotDataCyc.push_back(dcyc);
                gotStall.push_back(stl);
            end
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc   = cyc;
                    errAtDone = error;
                end
            end
            if (errCyc > 0 && cyc == errCyc + 1) begin
                checkOutput("abort error", 32'(error), 32'd1);
                checkOutput("abort dataValid", 32'(dataValid), 32'd0);
                checkOutput("abort requestBus", 32'(requestBus), 32'd0);
                checkOutput("abort done", 32'(done), 32'd1);
            end
            if (doneCyc >= 0 && cyc == doneCyc + 1) break;
            if (cyc >= BUDGET) begin
                checks++;
                errors++;
                $display("[TB] FAIL timeout: no done after %0d cycles, limit %0d", cyc, BUDGET);
                break;
            end
            @(posedge clock);
            #1;
            start = (cyc == midStartCyc);
            if (start) begin
                busStartAddress    = 32'hDEAD_0000;
                bufferStartAddress = AW'(7);
                blockSize          = (AW + 1)'(3);
                burstSize          = 8'd0;
            end
            busGrant = (int'($urandom_range(99)) < grantPct);
            if (dataValid) begin
                dataCyc++;
                busyIn  = (dataCyc <= 32 && stallMask[dataCyc-1]) || (int'($urandom_range(99)) < stallPct);
                errorIn = (dataCyc == errorAt);
                if (errorIn) errCyc = cyc + 1;
            end else begin
                busyIn  = (int'($urandom_range(99)) < stallPct);
                errorIn = 1'b0;
            end
        end
        start   = 1'b0;
        errorIn = 1'b0;
        busyIn  = 1'b0;

        checkOutput("done count", 32'(doneCnt), 32'd1);
        checkOutput("protocol violations", 32'(viol), 32'd0);
        mism = 0;
        for (int i = 0; i < gotWords.size(); i++) begin
            if (i >= expWords.size() || gotWords[i] !== expWords[i]) begin
                if (mism == 0) $display("[TB] word %0d got 0x%0h", i, gotWords[i]);
                mism++;
            end
        end
        checkOutput("word data mismatches", 32'(mism), 32'd0);
        if (errorAt <= 0) begin
            checkOutput("burst count", 32'(gotAddr.size()), 32'(expAddr.size()));
            for (int i = 0; i < gotAddr.size() && i < expAddr.size(); i++) begin
                checkOutput("burst address", gotAddr[i], expAddr[i]);
                checkOutput("burst length", 32'(gotLen[i]), 32'(expLen[i]));
            end
            for (int i = 0; i < gotAcc.size() && i < expLen.size(); i++) begin
                checkOutput("burst words accepted", 32'(gotAcc[i]), 32'(expLen[i]));
                checkOutput("burst data cycles", 32'(gotDataCyc[i]), 32'(expLen[i] + gotStall[i]));
            end
            checkOutput("end count", 32'(endCnt), 32'(expAddr.size()));
            checkOutput("word count", 32'(gotWords.size()), 32'(blockSz));
            checkOutput("error flag", 32'(errAtDone), 32'd0);
            checkOutput("request seen", 32'(reqSeen), 32'(blockSz != 0));
        end else begin
            checkOutput("abort end count", 32'(endCnt), 32'd0);
            checkOutput("abort error at done", 32'(errAtDone), 32'd1);
            checkOutput("error sticky", 32'(error), 32'd1);
        end
        nBursts    = gotAddr.size();
        doneCycOut = doneCyc;
    endtask

    typedef struct {
        logic [31:0] busStart;
        int          bufStart;
        int          blockSz;
        int          burstSz;
        int          expBursts;
        int          expDoneCycle;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nb, dc, w;
        logic sawDone, sawReq;

        for (int i = 0; i < ENTRIES; i++) mem[i] = $urandom;
        nReset = 1'b0; start = 1'b0; busStartAddress = '0; bufferStartAddress = '0;
        blockSize = '0; burstSize = '0; busGrant = 1'b0; busyIn = 1'b0; errorIn = 1'b0;

        #3;
        checkOutput("reset busy/done/error", {29'd0, busy, done, error}, 32'd0);
        checkOutput("reset bus strobes", {27'd0, requestBus, beginTransaction, endTransaction, dataValid, readNotWrite}, 32'd0);
        checkOutput("reset addressData", addressData, 32'd0);
        checkOutput("reset burstLength/bufAddress", {15'd0, burstLength, bufAddress}, 32'd0);
        @(negedge clock);
        nReset = 1'b1;

        vecs[0] = '{32'h0000_1000,   0,   4,   3, 1,   9};
        vecs[1] = '{32'h0000_1000,   0,  10,   3, 3,  21};
        vecs[2] = '{32'h0000_2003, 510,   4,   7, 1,   9};
        vecs[3] = '{32'h0000_0100,   5, 512, 255, 2, 520};
        vecs[4] = '{32'hFFFF_FFF8, 100,   5,   1, 3,  16};
        vecs[5] = '{32'h0000_0000,   0,   1,   0, 1,   6};
        vecs[6] = '{32'h0000_0040,   3,   7, 255, 1,  12};
        vecs[7] = '{32'h0000_0500,   0,   0,   3, 0,   2};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].busStart, vecs[i].bufStart, vecs[i].blockSz, vecs[i].burstSz,
                          100, 0, 32'd0, -1, -1, nb, dc);
            checkOutput($sformatf("vec%0d bursts", i), 32'(nb), 32'(vecs[i].expBursts));
            checkOutput($sformatf("vec%0d done cycle", i), 32'(dc), 32'(vecs[i].expDoneCycle));
        end

        // Stall on the 2nd and 3rd data cycles: six DATA cycles, two more than unstalled
        applyStimulus(32'h0000_1000, 0, 4, 3, 100, 0, 32'h6, -1, -1, nb, dc);
        checkOutput("stall done cycle", 32'(dc), 32'd11);

        // Start pulse in the middle of a transfer must be ignored
        applyStimulus(32'h0000_6000, 200, 12, 3, 100, 0, 32'd0, -1, 5, nb, dc);
        checkOutput("mid-start bursts", 32'(nb), 32'd3);

        // Abort on the 2nd data cycle
        applyStimulus(32'h0000_4000, 40, 8, 7, 100, 0, 32'd0, 2, -1, nb, dc);

        // Asynchronous reset in the middle of a burst
        @(posedge clock);
        #1;
        start = 1'b1; busStartAddress = 32'h0000_3000; bufferStartAddress = AW'(20);
        blockSize = (AW + 1)'(8); burstSize = 8'd7; busGrant = 1'b1; busyIn = 1'b0; errorIn = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        w = 0;
        while (!dataValid && w < 20) begin
            @(posedge clock);
            #1;
            w++;
        end
        @(posedge clock);
        #1;
        checkOutput("reset test in DATA", 32'(dataValid), 32'd1);
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("async reset busy/done/error", {29'd0, busy, done, error}, 32'd0);
        checkOutput("async reset bus strobes", {27'd0, requestBus, beginTransaction, endTransaction, dataValid, readNotWrite}, 32'd0);
        checkOutput("async reset addressData", addressData, 32'd0);
        checkOutput("async reset burstLength/bufAddress", {15'd0, burstLength, bufAddress}, 32'd0);
        @(negedge clock);
        nReset  = 1'b1;
        sawDone = 1'b0;
        sawReq  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done) sawDone = 1'b1;
            if (requestBus) sawReq = 1'b1;
        end
        checkOutput("no done after reset", 32'(sawDone), 32'd0);
        checkOutput("bus released after reset", 32'(sawReq), 32'd0);

        for (int r = 0; r < 25; r++) begin
            applyStimulus($urandom, int'($urandom_range(ENTRIES - 1)), int'($urandom_range(40)),
                          ($urandom_range(3) == 0) ? 255 : int'($urandom_range(15)),
                          60, 25, 32'd0, -1, -1, nb, dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/dma_buffer_drain.md
Name: dma_buffer_drain

Overview:
Bus-side transfer engine for the DMA block. It drains a block of 32-bit words from the DMA buffer memory's read port and writes them to system memory as a sequence of write bursts on the shared bus. It is the consumer of the buffer that the CPU side fills. It is configured and started by the DMA control registers, and reports busy, done and error back to them.

Parameters:
BUFFER_ENTRIES, 512, depth of the DMA buffer memory in words.
ADDR_W, $clog2(BUFFER_ENTRIES), buffer address width.
MAX_BURST, 256, largest burst length supported by the bus (words).

Ports:
clock  in  1  system clock; all logic on the rising edge.
nReset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that launches a transfer.
busStartAddress  in  32  byte address of the first destination word; bits [1:0] are ignored (treated as 0).
bufferStartAddress  in  ADDR_W  index of the first source word in the buffer.
blockSize  in  ADDR_W+1  number of words to move, 0..BUFFER_ENTRIES.
burstSize  in  8  words per burst minus 1.
busy  out  1  high from the cycle after start until done.
done  out  1  one-cycle pulse at the end of a transfer (normal or aborted).
error  out  1  sticky abort flag; cleared by the next accepted start.
bufAddress  out  ADDR_W  read address to the buffer memory port.
bufReadData  in  32  buffer read data, registered, 1-cycle latency.
requestBus  out  1  bus request.
busGrant  in  1  bus grant.
beginTransaction  out  1  start-of-burst strobe.
endTransaction  out  1  end-of-burst strobe.
readNotWrite  out  1  always 0 while driving the bus.
addressData  out  32  bus address in the begin cycle, write data in data cycles.
burstLength  out  8  burst length minus 1, valid in the begin cycle.
dataValid  out  1  write data is valid.
busyIn  in  1  target stall.
errorIn  in  1  bus error.

Behaviour:
- Reset (asynchronous, nReset=0): state IDLE. busy, done, error, requestBus, beginTransaction, endTransaction, dataValid and readNotWrite all reset to 0. addressData, burstLength and bufAddress reset to 0.
- Bus outputs other than requestBus are 0 whenever the engine is not in BEGIN, DATA or END.
- FSM states: IDLE, REQUEST, BEGIN, DATA, END, DONE.
- IDLE:
  - On start, latch busAddr, bufIdx (= bufferStartAddress), remaining (= blockSize) and burstSize; clear error.
  - If blockSize is 0, go to DONE with no bus activity. Otherwise go to REQUEST.
  - start is ignored in every state other than IDLE.
- REQUEST: requestBus=1. When busGrant=1, compute len = min(burstSize+1, remaining, MAX_BURST) and go to BEGIN.
- BEGIN (exactly 1 cycle):
  - beginTransaction=1, addressData=busAddr, burstLength=len-1, readNotWrite=0.
  - bufAddress=bufIdx, so the first word appears on bufReadData in the first DATA cycle.
- DATA:
  - dataValid=1 and addressData=bufReadData.
  - A word is accepted when dataValid=1 and busyIn=0.
  - bufAddress is driven combinationally: bufIdx+1 on an accept cycle, bufIdx otherwise. This gives a back-to-back stream with no bubbles; on stall cycles the same word is re-read and held.
  - Each accept: bufIdx+1 (modulo BUFFER_ENTRIES, so it wraps from BUFFER_ENTRIES-1 to 0), busAddr+4 (32-bit wrap), remaining-1, burst count-1.
  - On acceptance of the last word of the burst, go to END.
- END (1 cycle): endTransaction=1, requestBus=0. Then go to REQUEST if remaining>0, else DONE. The bus is re-arbitrated between bursts.
- DONE (1 cycle): done=1, then go to IDLE.
- Error handling:
  - errorIn=1 in BEGIN or DATA aborts the transfer: set error=1, drop requestBus and dataValid, assert no endTransaction, go to DONE.
  - error stays high until the next accepted start.
- busy is 1 in every state except IDLE.
- Throughput: an N-word burst with no stalls occupies 1 BEGIN + N DATA + 1 END cycles after grant.
- Reset mid-transfer: all outputs drop asynchronously to their reset values. The bus is released immediately. No done pulse is produced.

Test Plan:
- Single burst: buffer[0..3]=A0..A3, start with busStartAddress=0x1000, bufferStartAddress=0, blockSize=4, burstSize=3, grant held -> one begin with addr 0x1000 and burstLength 3; 4 consecutive dataValid cycles carrying A0..A3; one endTransaction; done one cycle later; error=0.
- Multi-burst with remainder: blockSize=10, burstSize=3 -> three bursts of lengths 4, 4, 2 at addresses 0x1000, 0x1010 and 0x1020; requestBus drops for one cycle between bursts; data order is preserved.
- Stall: busyIn=1 on the 2nd and 3rd data cycles of a 4-word burst -> word 1 is held stable for 3 cycles; no word is lost or duplicated; the burst takes 6 DATA cycles.
- Buffer wrap: bufferStartAddress=510, blockSize=4 -> words are taken from indices 510, 511, 0, 1 in that order.
- Zero length and ignored start: blockSize=0 -> done 2 cycles after start with requestBus never asserted. A start pulse issued during a transfer is ignored and does not disturb it.
- Error and reset: errorIn=1 on the 2nd data cycle -> error=1, dataValid=0 and requestBus=0 the next cycle, done pulses, no endTransaction. Separately, nReset=0 mid-burst -> all outputs return to 0 asynchronously.
